// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
//
// Latches the execute-stage bus, checks load/store alignment, and issues at
// most one request per load/store on the req/addr_ok/data_ok data-SRAM port.
// It merges and extends load data, then hands a 191-bit bus to write-back. It
// also feeds a forwarding bus back to decode.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   es_to_ms_valid/bus      execute-stage handoff: {ld_op[4:0], st_op[2:0], st_data[31:0], payload[190:0]}
//   ms_allowin              this stage can accept this cycle
//   ws_allowin              write-back can accept
//   ws_ertn_flush           exception/ertn flush from write-back
//   ms_to_ws_valid/bus      write-back handoff (payload with ale and final_result updated)
//   ms_to_ds_bus            {able, dest[4:0], data[31:0], csr_we, csr_related}
//   ms_ex                   instruction here carries an exception or ertn
//   data_sram_*             request/response data-SRAM port
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         es_to_ms_valid,
  input  logic [230:0] es_to_ms_bus,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  input  logic         ws_ertn_flush,
  output logic         ms_to_ws_valid,
  output logic [190:0] ms_to_ws_bus,
  output logic [39:0]  ms_to_ds_bus,
  output logic         ms_ex,
  output logic         data_sram_req,
  output logic         data_sram_wr,
  output logic [1:0]   data_sram_size,
  output logic [31:0]  data_sram_addr,
  output logic [3:0]   data_sram_wstrb,
  output logic [31:0]  data_sram_wdata,
  input  logic         data_sram_addr_ok,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata
);

  // Payload layout, MSB first; the packed struct matches the bus bit order.
  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
    logic        adef;
    logic        ine;
    logic        sys;
    logic        ale;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        res_from_csr;
    logic        brk;
    logic [1:0]  rdcnt_detail;
    logic [31:0] mem_addr;
  } ms_pl_t;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  state_t      state;
  logic        ms_valid;
  logic [4:0]  ld_r;
  logic [2:0]  st_r;
  logic [31:0] sd_r;
  ms_pl_t      pl_r;
  logic [31:0] ld_data_r;

  // ---------------- incoming instruction decode (for the accept decision)
  logic [4:0]  in_ld;
  logic [2:0]  in_st;
  logic [31:0] in_sd;
  ms_pl_t      in_pl;
  logic        in_ale, in_exc, in_need;

  assign {in_ld, in_st, in_sd, in_pl} = es_to_ms_bus;
  assign in_ale  = ((in_ld[2] | in_ld[1] | in_st[1]) & in_pl.mem_addr[0]) |
                   ((in_ld[0] | in_st[0]) & (in_pl.mem_addr[1:0] != 2'b00));
  assign in_exc  = in_pl.adef | in_pl.ine | in_pl.sys | in_pl.ale | in_ale |
                   in_pl.brk | in_pl.ertn;
  assign in_need = ((|in_ld) | (|in_st)) & ~in_exc;

  // ---------------- latched instruction decode
  logic r_byte, r_half, r_word, r_ale, r_exc, is_load, ready_go, accept, able;

  assign r_byte  = ld_r[4] | ld_r[3] | st_r[2];
  assign r_half  = ld_r[2] | ld_r[1] | st_r[1];
  assign r_word  = ld_r[0] | st_r[0];
  assign r_ale   = (r_half & pl_r.mem_addr[0]) |
                   (r_word & (pl_r.mem_addr[1:0] != 2'b00));
  assign r_exc   = pl_r.adef | pl_r.ine | pl_r.sys | pl_r.ale | r_ale |
                   pl_r.brk | pl_r.ertn;
  assign is_load = |ld_r;

  assign ready_go       = (state == S_DONE);
  assign ms_to_ws_valid = ms_valid & ready_go & ~ws_ertn_flush;
  // Outstanding bus traffic (REQ/WAIT/CANCEL) blocks new instructions so
  // that every data_ok is matched to the request that produced it.
  assign ms_allowin     = (~ms_valid | (ready_go & ws_allowin)) &
                          (state != S_CANCEL) & (state != S_REQ) & (state != S_WAIT);
  assign accept         = es_to_ms_valid & ms_allowin;
  assign ms_ex          = ms_valid & r_exc;

  // ---------------- SRAM request fields (held constant by the latched bus)
  assign data_sram_req  = (state == S_REQ);
  assign data_sram_wr   = |st_r;
  assign data_sram_size = r_byte ? 2'd0 : r_half ? 2'd1 : 2'd2;
  assign data_sram_addr = pl_r.mem_addr;

  always_comb begin
    data_sram_wstrb = 4'b0000;
    if (|st_r) begin
      if (r_byte)      data_sram_wstrb = 4'b0001 << pl_r.mem_addr[1:0];
      else if (r_half) data_sram_wstrb = pl_r.mem_addr[1] ? 4'b1100 : 4'b0011;
      else             data_sram_wstrb = 4'b1111;
    end
    data_sram_wdata = r_byte ? {4{sd_r[7:0]}} : r_half ? {2{sd_r[15:0]}} : sd_r;
  end

  // ---------------- load data select and extend
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ld_res, final_res;

  always_comb begin
    sel_h = pl_r.mem_addr[1] ? ld_data_r[31:16] : ld_data_r[15:0];
    case (pl_r.mem_addr[1:0])
      2'd0:    sel_b = ld_data_r[7:0];
      2'd1:    sel_b = ld_data_r[15:8];
      2'd2:    sel_b = ld_data_r[23:16];
      default: sel_b = ld_data_r[31:24];
    endcase
    ld_res = ld_data_r;
    if (ld_r[4])      ld_res = {{24{sel_b[7]}}, sel_b};
    else if (ld_r[3]) ld_res = {24'b0, sel_b};
    else if (ld_r[2]) ld_res = {{16{sel_h[15]}}, sel_h};
    else if (ld_r[1]) ld_res = {16'b0, sel_h};
  end

  // An excepting load never fetched data, so its result field passes through.
  assign final_res = (is_load & ~r_exc) ? ld_res : pl_r.final_result;

  ms_pl_t pl_o;
  always_comb begin
    pl_o              = pl_r;
    pl_o.ale          = pl_r.ale | r_ale;
    pl_o.final_result = final_res;
  end
  assign ms_to_ws_bus = pl_o;

  // A load still in flight cannot forward its result yet.
  assign able = ~(ms_valid & is_load & ~ready_go);
  assign ms_to_ds_bus = {able, pl_r.dest & {5{ms_valid}}, final_res,
                         pl_r.csr_we & ms_valid,
                         (pl_r.csr_re | pl_r.csr_we) & ms_valid};

  // ---------------- state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ms_valid  <= 1'b0;
      ld_r      <= '0;
      st_r      <= '0;
      sd_r      <= '0;
      pl_r      <= '0;
      ld_data_r <= '0;
    end else begin
      if (ws_ertn_flush)   ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es_to_ms_valid;

      if (accept) begin
        ld_r <= in_ld;
        st_r <= in_st;
        sd_r <= in_sd;
        pl_r <= in_pl;
      end

      // Responses arriving in CANCEL (or alongside a flush) are dropped.
      if (state == S_WAIT && data_sram_data_ok && !ws_ertn_flush)
        ld_data_r <= data_sram_rdata;

      if (ws_ertn_flush) begin
        case (state)
          S_REQ:    state <= data_sram_addr_ok ? S_CANCEL : S_IDLE;
          S_WAIT:   state <= data_sram_data_ok ? S_IDLE : S_CANCEL;
          S_CANCEL: state <= data_sram_data_ok ? S_IDLE : S_CANCEL;
          default:  state <= S_IDLE;
        endcase
      end else begin
        case (state)
          S_IDLE, S_DONE:
            if (ms_allowin)
              state <= !es_to_ms_valid ? S_IDLE : in_need ? S_REQ : S_DONE;
          S_REQ:    if (data_sram_addr_ok) state <= S_WAIT;
          S_WAIT:   if (data_sram_data_ok) state <= S_DONE;
          S_CANCEL: if (data_sram_data_ok) state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// loads/stores/non-memory instructions against a behavioural model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_to_ms_valid;
  logic [230:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ws_ertn_flush;
  logic         ms_to_ws_valid;
  logic [190:0] ms_to_ws_bus;
  logic [39:0]  ms_to_ds_bus;
  logic         ms_ex;
  logic         data_sram_req, data_sram_wr;
  logic [1:0]   data_sram_size;
  logic [31:0]  data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]   data_sram_wstrb;
  logic         data_sram_addr_ok, data_sram_data_ok;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin), .ws_ertn_flush(ws_ertn_flush),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ms_to_ds_bus(ms_to_ds_bus), .ms_ex(ms_ex),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
    logic        adef, ine, sys, ale;
    logic        csr_re, csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue;
    logic        ertn, res_from_csr, brk;
    logic [1:0]  rdcnt_detail;
    logic [31:0] mem_addr;
  } fld_t;

  int checks = 0;
  int errors = 0;

  function automatic fld_t rand_fld();
    logic [191:0] r;
    fld_t f;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    f = r[190:0];
    f.adef = 0; f.ine = 0; f.sys = 0; f.ale = 0; f.brk = 0; f.ertn = 0;
    return f;
  endfunction

  // Load result from plain arithmetic: shift the addressed unit down, mask,
  // and sign-extend with the xor/subtract identity.
  function automatic logic [31:0] ld_model(logic [4:0] ld, logic [31:0] a, logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    if (ld[4]) return (b ^ 32'h80) - 32'h80;
    if (ld[3]) return b;
    if (ld[2]) return (h ^ 32'h8000) - 32'h8000;
    if (ld[1]) return h;
    return rd;
  endfunction

  // One instruction through the stage with the bench acting as SRAM:
  // addr_ok after alat request cycles, data_ok dlat cycles after that, and
  // write-back refusing for `stall` cycles once the result is ready.
  task automatic run_txn(input fld_t f, input logic [4:0] ld, input logic [2:0] st,
                         input logic [31:0] sd, input logic [31:0] rd,
                         input int alat, input int dlat, input int stall, input string tag,
                         output logic [31:0] o_res, output logic [1:0] o_size,
                         output logic [3:0] o_wstrb, output logic [31:0] o_wdata,
                         output logic o_wr);
    int bytes, rcnt, dcnt, scnt;
    logic [31:0] a, exp_res, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [1:0]  exp_size;
    logic is_ld, mem, ale, exc, need;
    logic addr_done, data_done, fin, exp_rq, exp_dn, g_a, g_d;
    fld_t g, ob;
    a     = f.mem_addr;
    is_ld = (ld != 0);
    mem   = is_ld || (st != 0);
    bytes = (ld[4] | ld[3] | st[2]) ? 1 : (ld[2] | ld[1] | st[1]) ? 2 : 4;
    ale   = mem && ((a % bytes) != 0);
    exc   = f.adef | f.ine | f.sys | f.ale | ale | f.brk | f.ertn;
    need  = mem && !exc;
    exp_size  = (bytes == 1) ? 2'd0 : (bytes == 2) ? 2'd1 : 2'd2;
    exp_wstrb = (st != 0) ? 4'(((1 << bytes) - 1) << (a[1:0] & 2'(4 - bytes))) : 4'b0000;
    exp_wdata = (bytes == 1) ? sd[7:0] * 32'h0101_0101 :
                (bytes == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    exp_res   = (is_ld && !exc) ? ld_model(ld, a, rd) : f.final_result;
    g = f;
    g.ale = f.ale | ale;
    g.final_result = exp_res;
    o_res = 0; o_size = 0; o_wstrb = 0; o_wdata = 0; o_wr = 0;

    @(negedge clk);
    es_to_ms_valid = 1; es_to_ms_bus = {ld, st, sd, f}; ws_allowin = 1;
    data_sram_addr_ok = 0; data_sram_data_ok = 0;
    #1;
    checks++;
    if (ms_allowin !== 1'b1) begin
      errors++; $display("FAIL %s accept: ms_allowin=%b required 1", tag, ms_allowin);
    end
    @(posedge clk);

    addr_done = 0; data_done = 0; fin = 0; rcnt = 0; dcnt = 0; scnt = 0;
    for (int c = 0; c < 64 && !fin; c++) begin
      @(negedge clk);
      es_to_ms_valid = 0; es_to_ms_bus = ~es_to_ms_bus;
      exp_rq = need && !addr_done;
      exp_dn = !need || data_done;
      g_a = exp_rq && (rcnt >= alat);
      g_d = need && addr_done && !data_done && (dcnt >= dlat);
      data_sram_addr_ok = g_a;
      data_sram_data_ok = g_d;
      data_sram_rdata   = g_d ? rd : $urandom;
      ws_allowin = !exp_dn || (scnt >= stall);
      #1;
      checks++;
      if (data_sram_req !== exp_rq) begin
        errors++; $display("FAIL %s req cyc%0d: got %b required %b", tag, c, data_sram_req, exp_rq);
      end
      if (exp_rq) begin
        checks++;
        if ({data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata} !==
            {st != 0, exp_size, a, exp_wstrb, exp_wdata}) begin
          errors++;
          $display("FAIL %s req fields: wr=%b size=%0d addr=%h wstrb=%b wdata=%h required wr=%b size=%0d addr=%h wstrb=%b wdata=%h",
                   tag, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
                   st != 0, exp_size, a, exp_wstrb, exp_wdata);
        end
        o_size = data_sram_size; o_wstrb = data_sram_wstrb; o_wdata = data_sram_wdata; o_wr = data_sram_wr;
      end
      checks++;
      if (ms_to_ws_valid !== exp_dn) begin
        errors++; $display("FAIL %s ws_valid cyc%0d: got %b required %b", tag, c, ms_to_ws_valid, exp_dn);
      end
      checks++;
      if (ms_allowin !== (exp_dn && ws_allowin)) begin
        errors++; $display("FAIL %s allowin cyc%0d: got %b required %b", tag, c, ms_allowin, exp_dn && ws_allowin);
      end
      checks++;
      if (ms_ex !== exc) begin
        errors++; $display("FAIL %s ms_ex: got %b required %b", tag, ms_ex, exc);
      end
      checks++;
      if ({ms_to_ds_bus[39:34], ms_to_ds_bus[1:0]} !==
          {!is_ld || exp_dn, f.dest, f.csr_we, f.csr_re | f.csr_we}) begin
        errors++; $display("FAIL %s ds ctrl: got able=%b dest=%0d csr=%b required able=%b dest=%0d csr=%b%b",
                           tag, ms_to_ds_bus[39], ms_to_ds_bus[38:34], ms_to_ds_bus[1:0],
                           !is_ld || exp_dn, f.dest, f.csr_we, f.csr_re | f.csr_we);
      end
      if (exp_dn) begin
        checks++;
        if (ms_to_ws_bus !== 191'(g)) begin
          errors++; $display("FAIL %s ws_bus: got %h required %h", tag, ms_to_ws_bus, 191'(g));
        end
        checks++;
        if (ms_to_ds_bus[33:2] !== exp_res) begin
          errors++; $display("FAIL %s ds data: got %h required %h", tag, ms_to_ds_bus[33:2], exp_res);
        end
        if (ws_allowin) begin
          fin = 1; ob = ms_to_ws_bus; o_res = ob.final_result;
        end else scnt++;
      end
      if (exp_rq) begin
        if (g_a) addr_done = 1; else rcnt++;
      end else if (g_d) data_done = 1;
      else if (need && addr_done && !data_done) dcnt++;
      @(posedge clk);
    end
    if (!fin) begin
      checks++; errors++; $display("FAIL %s timeout: no handoff within 64 cycles", tag);
    end
    @(negedge clk);
    data_sram_addr_ok = 0; data_sram_data_ok = 0;
  endtask

  task automatic test_reset();
    reset = 1; es_to_ms_valid = 0; es_to_ms_bus = '0; ws_allowin = 1; ws_ertn_flush = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({data_sram_req, ms_to_ws_valid, ms_ex, ms_allowin} !== 4'b0001) begin
      errors++; $display("FAIL reset ctrl: req/valid/ex/allowin=%b required 0001",
                         {data_sram_req, ms_to_ws_valid, ms_ex, ms_allowin});
    end
    checks++;
    if (ms_to_ds_bus !== 40'h80_0000_0000) begin
      errors++; $display("FAIL reset ds_bus: got %h required 8000000000", ms_to_ds_bus);
    end
    checks++;
    if (ms_to_ws_bus !== 191'b0) begin
      errors++; $display("FAIL reset ws_bus: got %h required 0", ms_to_ws_bus);
    end
    reset = 0;
  endtask

  task automatic test_load();
    fld_t f; logic [31:0] r, w; logic [1:0] s; logic [3:0] m; logic x;
    f = rand_fld(); f.mem_addr = 32'h1C00_0100;
    run_txn(f, 5'b00001, 3'b000, 32'h0, 32'h8765_4321, 0, 0, 0, "ld_w", r, s, m, w, x);
    checks++;
    if (r !== 32'h8765_4321) begin errors++; $display("FAIL ld_w result: got %h required 87654321", r); end
    f = rand_fld(); f.mem_addr = 32'h1C00_0103;
    run_txn(f, 5'b10000, 3'b000, 32'h0, 32'h80FF_0000, 0, 0, 0, "ld_b", r, s, m, w, x);
    checks++;
    if (r !== 32'hFFFF_FF80) begin errors++; $display("FAIL ld_b result: got %h required ffffff80", r); end
    f = rand_fld(); f.mem_addr = 32'h1C00_0102;
    run_txn(f, 5'b00010, 3'b000, 32'h0, 32'h80FF_0000, 1, 2, 0, "ld_hu", r, s, m, w, x);
    checks++;
    if (r !== 32'h0000_80FF) begin errors++; $display("FAIL ld_hu result: got %h required 000080ff", r); end
  endtask

  task automatic test_store();
    fld_t f; logic [31:0] r, w; logic [1:0] s; logic [3:0] m; logic x;
    f = rand_fld(); f.mem_addr = 32'h1C00_0102;
    run_txn(f, 5'b00000, 3'b010, 32'h1234_ABCD, 32'h0, 2, 1, 0, "st_h", r, s, m, w, x);
    checks++;
    if ({x, s, m, w} !== {1'b1, 2'd1, 4'b1100, 32'hABCD_ABCD}) begin
      errors++; $display("FAIL st_h fields: wr=%b size=%0d wstrb=%b wdata=%h required wr=1 size=1 wstrb=1100 wdata=abcdabcd",
                         x, s, m, w);
    end
  endtask

  task automatic test_ale();
    fld_t f; logic [31:0] r, w; logic [1:0] s; logic [3:0] m; logic x;
    f = rand_fld(); f.mem_addr = 32'h1C00_0101; f.final_result = 32'h5A5A_1234;
    run_txn(f, 5'b00001, 3'b000, 32'h0, 32'h0, 0, 0, 0, "ale", r, s, m, w, x);
    checks++;
    if (r !== 32'h5A5A_1234) begin errors++; $display("FAIL ale result: got %h required 5a5a1234", r); end
  endtask

  task automatic test_stall();
    fld_t f; logic [31:0] r, w; logic [1:0] s; logic [3:0] m; logic x;
    f = rand_fld(); f.mem_addr = 32'h1C00_0208;
    run_txn(f, 5'b00001, 3'b000, 32'h0, 32'hCAFE_F00D, 0, 0, 4, "stall", r, s, m, w, x);
    checks++;
    if (r !== 32'hCAFE_F00D) begin errors++; $display("FAIL stall result: got %h required cafef00d", r); end
  endtask

  task automatic test_flush_req();
    fld_t f;
    f = rand_fld(); f.mem_addr = 32'h1C00_0300;
    @(negedge clk); es_to_ms_valid = 1; es_to_ms_bus = {5'b00001, 3'b000, 32'h0, f};
    @(negedge clk); es_to_ms_valid = 0; ws_ertn_flush = 1; data_sram_addr_ok = 0;
    #1;
    checks++;
    if ({data_sram_req, ms_allowin, ms_to_ws_valid} !== 3'b100) begin
      errors++; $display("FAIL flush_req in REQ: req/allowin/valid=%b required 100",
                         {data_sram_req, ms_allowin, ms_to_ws_valid});
    end
    @(negedge clk); ws_ertn_flush = 0;
    #1;
    checks++;
    if ({data_sram_req, ms_allowin, ms_to_ws_valid} !== 3'b010) begin
      errors++; $display("FAIL flush_req after: req/allowin/valid=%b required 010",
                         {data_sram_req, ms_allowin, ms_to_ws_valid});
    end
  endtask

  task automatic test_cancel();
    fld_t f;
    f = rand_fld(); f.mem_addr = 32'h1C00_0400;
    @(negedge clk); es_to_ms_valid = 1; es_to_ms_bus = {5'b00001, 3'b000, 32'h0, f};
    @(negedge clk); es_to_ms_valid = 0; data_sram_addr_ok = 1;
    @(negedge clk); data_sram_addr_ok = 0; ws_ertn_flush = 1;
    #1;
    checks++;
    if ({ms_to_ws_valid, ms_allowin} !== 2'b00) begin
      errors++; $display("FAIL cancel flush cyc: valid/allowin=%b required 00", {ms_to_ws_valid, ms_allowin});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ws_ertn_flush = 0; data_sram_data_ok = (i == 2); data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({data_sram_req, ms_to_ws_valid, ms_allowin} !== 3'b000) begin
        errors++; $display("FAIL cancel wait%0d: req/valid/allowin=%b required 000", i,
                           {data_sram_req, ms_to_ws_valid, ms_allowin});
      end
    end
    @(negedge clk); data_sram_data_ok = 0;
    #1;
    checks++;
    if ({data_sram_req, ms_to_ws_valid, ms_allowin} !== 3'b001) begin
      errors++; $display("FAIL cancel after data_ok: req/valid/allowin=%b required 001",
                         {data_sram_req, ms_to_ws_valid, ms_allowin});
    end
  endtask

  task automatic test_reset_mid();
    fld_t f;
    f = rand_fld(); f.mem_addr = 32'h1C00_0500;
    @(negedge clk); es_to_ms_valid = 1; es_to_ms_bus = {5'b00001, 3'b000, 32'h0, f};
    @(negedge clk); es_to_ms_valid = 0;
    #1;
    checks++;
    if (data_sram_req !== 1'b1) begin errors++; $display("FAIL reset_mid pre: req=%b required 1", data_sram_req); end
    #1 reset = 1;
    #1;
    checks++;
    if ({data_sram_req, ms_to_ws_valid, ms_allowin} !== 3'b001) begin
      errors++; $display("FAIL reset_mid: req/valid/allowin=%b required 001",
                         {data_sram_req, ms_to_ws_valid, ms_allowin});
    end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_back_to_back();
    fld_t q[6];
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      ws_allowin = 1;
      es_to_ms_valid = (i < 6);
      if (i < 6) begin q[i] = rand_fld(); es_to_ms_bus = {5'b0, 3'b0, $urandom, q[i]}; end
      #1;
      checks++;
      if (ms_allowin !== 1'b1) begin errors++; $display("FAIL b2b%0d allowin: got %b required 1", i, ms_allowin); end
      if (i > 0) begin
        checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== 191'(q[i-1])) begin
          errors++; $display("FAIL b2b%0d handoff: valid=%b bus=%h required 1 %h", i,
                             ms_to_ws_valid, ms_to_ws_bus, 191'(q[i-1]));
        end
      end
    end
    @(negedge clk); es_to_ms_valid = 0;
  endtask

  task automatic test_random();
    fld_t f; logic [31:0] r, w; logic [1:0] s; logic [3:0] m; logic x;
    logic [4:0] ld; logic [2:0] st; int k;
    for (int n = 0; n < 40; n++) begin
      f = rand_fld();
      k = $urandom_range(0, 9);
      ld = (k < 5) ? 5'(1 << k) : 5'b0;
      st = (k >= 5 && k < 8) ? 3'(1 << (k - 5)) : 3'b0;
      if ($urandom_range(0, 1) == 0) f.mem_addr[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: f.adef = 1;
          1: f.ine  = 1;
          2: f.sys  = 1;
          3: f.ale  = 1;
          4: f.brk  = 1;
          default: f.ertn = 1;
        endcase
      end
      run_txn(f, ld, st, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), $sformatf("rand%0d", n), r, s, m, w, x);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_ale();
    test_stall();
    test_flush_req();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and the write-back stage. It latches the execute-stage bus, checks load/store alignment, and issues one request per load or store on the request/response data-SRAM port. It merges and extends load data, then forwards a 191-bit bus to write-back. It also drives a forwarding bus to decode and aborts cleanly when write-back raises an exception/ertn flush.

## Interface
- No parameters. Bus widths: ES_TO_MS 231, MS_TO_WS 191, MS_TO_DS 40.
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- es_to_ms_valid  in  1  execute stage holds a valid instruction
- es_to_ms_bus  in  231  {ld_op[4:0] one-hot {ld_b,ld_bu,ld_h,ld_hu,ld_w}, st_op[2:0] one-hot {st_b,st_h,st_w}, st_data[31:0], payload[190:0]}
- ms_allowin  out  1  stage can accept this cycle
- ws_allowin  in  1  write-back can accept
- ws_ertn_flush  in  1  flush from write-back (exception/ertn/interrupt)
- ms_to_ws_valid  out  1
- ms_to_ws_bus  out  191  payload MSB-first: gr_we, dest[4:0], final_result[31:0], pc[31:0], adef, ine, sys, ale, csr_re, csr_we, csr_num[13:0], csr_wmask[31:0], csr_wvalue[31:0], ertn, res_from_csr, break, rdcnt_detail[1:0], mem_addr[31:0]
- ms_to_ds_bus  out  40  {able, dest[4:0], data[31:0], csr_we, csr_related}
- ms_ex  out  1  instruction here carries exception or ertn; execute stage must suppress younger stores
- data_sram_req  out  1;  data_sram_wr  out  1;  data_sram_size  out  2 (0 byte, 1 half, 2 word)
- data_sram_addr  out  32;  data_sram_wstrb  out  4;  data_sram_wdata  out  32
- data_sram_addr_ok  in  1;  data_sram_data_ok  in  1;  data_sram_rdata  in  32

## Operation
- Accept: on es_to_ms_valid && ms_allowin, latch bus. ms_valid <= es_to_ms_valid whenever ms_allowin. ms_valid <= 0 on ws_ertn_flush.
- Memory access is needed when ld_op or st_op is non-zero. Address = payload mem_addr.
- ALE: half access with addr[0]≠0, or word access with addr[1:0]≠0 → set ale bit in outgoing payload.
- Exception = any of adef/ine/sys/ale/break or ertn. An excepting instruction issues no request.
- FSM states IDLE, REQ, WAIT, DONE, CANCEL.
  - On accept: REQ if access needed and no exception, else DONE.
  - REQ: data_sram_req=1, fields driven from latched bus. addr_ok → WAIT.
  - WAIT: data_ok → capture rdata, DONE.
  - DONE: on handoff (ms_to_ws_valid && ws_allowin) → next accepted instr's state, or IDLE.
  - Flush in REQ without addr_ok → IDLE. Flush in REQ with addr_ok, or in WAIT without data_ok → CANCEL. CANCEL: data_ok → IDLE. Flush in WAIT with data_ok → IDLE.
- ready_go = state==DONE. ms_to_ws_valid = ms_valid && ready_go && !ws_ertn_flush.
- ms_allowin = (!ms_valid || (ready_go && ws_allowin)) && state≠CANCEL && state≠REQ && state≠WAIT.
- Store: wr=1. wstrb: byte 1<<addr[1:0]; half addr[1]?1100:0011; word 1111. wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d. Load: wr=0, wstrb 0.
- Load result: select byte addr[1:0] / half addr[1], sign-extend (ld_b, ld_h) or zero-extend (bu, hu). It replaces final_result. Non-loads pass final_result unchanged.
- Forwarding: dest = dest&{5{ms_valid}}. able = 0 while a load is valid and not DONE, else 1. data = final/load result. csr_we = csr_we&ms_valid. csr_related = (csr_re|csr_we)&ms_valid.

## Timing
- Reset values: state IDLE, ms_valid 0, all latched bus bits 0, load-data reg 0. Hence data_sram_req 0, ms_to_ws_valid 0, ms_ex 0, ms_allowin 1.
- Request earliest cycle after accept. Load with addr_ok and data_ok each in the first possible cycle: DONE 2 cycles after accept. Non-memory instruction: DONE immediately after accept (1-cycle stage).
- req is held with constant fields until addr_ok. At most one outstanding request.
- data_ok in CANCEL is consumed silently, with no capture and no valid.
- Reset mid-transaction returns to IDLE immediately. Bus-side draining is the SRAM bridge's reset duty.

## Test plan
- ld_w addr 0x1C00_0100, addr_ok and data_ok 1 cycle each, rdata 0x8765_4321 → ws final_result 0x8765_4321; able=0 until DONE.
- ld_b addr 0x…03, rdata 0x80FF_0000 → 0xFFFF_FF80; ld_hu addr 0x…02 → 0x0000_80FF.
- st_h addr 0x…02, data 0x1234_ABCD → size 1, wstrb 1100, wdata 0xABCD_ABCD, wr 1.
- ld_w addr 0x…01 → ale=1, no req, ms_ex=1, forwarded in 1 cycle.
- Load in WAIT, ws_ertn_flush pulse, data_ok 3 cycles later → CANCEL, ms_allowin 0 for those cycles, no ms_to_ws_valid, IDLE after data_ok.
- ws_allowin low 4 cycles with DONE → output and bus stable, ms_allowin 0, no extra request.
